// File: rtl/cordic_mult_approx_param.sv
// Iterative linear-mode CORDIC signed multiplier with a lower-part-OR (LOA) accumulator adder.
// One multiply in flight; start is accepted in IDLE, busy covers ITER/CORR, done pulses with y.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// ITER  | one shift-add iteration per cycle, i counts down from W-1 to 0
// CORR  | apply the residual +1/-1 of zr as a final +/-x
// DONE  | load y and raise done for the following cycle
module cordic_mult_approx_param #(
    parameter int W        = 8,
    parameter int APX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             approx_en,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     z,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   y
);

    localparam int AW = 2*W + 1;
    localparam int ZW = W + 2;
    localparam int IW = $clog2(W);
    // Slice width used for the OR section; kept >= 1 so APX_BITS=0 still elaborates.
    localparam int KE = (APX_BITS == 0) ? 1 : APX_BITS;
    localparam logic [IW-1:0] I_INIT = IW'(W - 1);
    localparam logic [ZW-1:0] Z_ONE  = ZW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_CORR = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    x_r;
    logic            apx_r;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_nxt;
    logic [AW-1:0]   xs;
    logic [AW-1:0]   sh;
    logic [AW-1:0]   b_iter;
    logic [ZW-1:0]   zr;
    logic [ZW-1:0]   zr_nxt;
    logic [ZW-1:0]   z_pow;
    logic [IW-1:0]   i_cnt;

    function automatic logic [AW-1:0] loa_add(
        input logic [AW-1:0] a,
        input logic [AW-1:0] b,
        input logic          apx
    );
        logic [AW-KE-1:0] hi;
        logic [KE-1:0]    lo;
        logic             c;
        if (!apx || APX_BITS == 0) begin
            return a + b;
        end
        lo = a[KE-1:0] | b[KE-1:0];
        // Carry into the exact part is guessed from the top OR'd bit pair only.
        c  = a[KE-1] & b[KE-1];
        hi = a[AW-1:KE] + b[AW-1:KE] + (AW-KE)'(c);
        return {hi, lo};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ITER;
            S_ITER:  if (i_cnt == '0) state_nxt = S_CORR;
            S_CORR:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_ITER) || (state == S_CORR);
    end

    always_comb begin
        xs     = {{(W+1){x_r[W-1]}}, x_r};
        sh     = xs << i_cnt;
        z_pow  = Z_ONE << i_cnt;
        b_iter = zr[ZW-1] ? -sh : sh;
        zr_nxt = zr[ZW-1] ? (zr + z_pow) : (zr - z_pow);
        acc_nxt = acc;
        case (state)
            S_ITER: acc_nxt = loa_add(acc, b_iter, apx_r);
            S_CORR: begin
                if (zr == Z_ONE) begin
                    acc_nxt = loa_add(acc, xs, apx_r);
                end else if (zr == '1) begin
                    acc_nxt = loa_add(acc, -xs, apx_r);
                end
            end
            default: acc_nxt = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_r   <= '0;
            apx_r <= 1'b0;
            acc   <= '0;
            zr    <= '0;
            i_cnt <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_r   <= x;
                        apx_r <= approx_en;
                        acc   <= '0;
                        zr    <= {{2{z[W-1]}}, z};
                        i_cnt <= I_INIT;
                    end
                end
                S_ITER: begin
                    acc <= acc_nxt;
                    zr  <= zr_nxt;
                    if (i_cnt != '0) begin
                        i_cnt <= i_cnt - 1'b1;
                    end
                end
                S_CORR: begin
                    acc <= acc_nxt;
                end
                S_DONE: begin
                    y <= acc[2*W-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_mult_approx_param.sv
// Directed bench for cordic_mult_approx_param: an 8-bit LOA instance and a 12-bit exact instance.
module tb_cordic_mult_approx_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, ae8, busy8, done8;
    logic [7:0]  x8, z8;
    logic [15:0] y8;
    logic        start12, ae12, busy12, done12;
    logic [11:0] x12, z12;
    logic [23:0] y12;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cordic_mult_approx_param #(.W(8), .APX_BITS(2)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .approx_en(ae8),
        .x(x8), .z(z8), .busy(busy8), .done(done8), .y(y8)
    );

    cordic_mult_approx_param #(.W(12), .APX_BITS(0)) u_dut12 (
        .clk(clk), .rst(rst), .start(start12), .approx_en(ae12),
        .x(x12), .z(z12), .busy(busy12), .done(done12), .y(y12)
    );

    // 17-bit accumulator adder, OR on the low two bits when apx is set.
    function automatic int add17(input int a, input int b, input logic apx);
        int am, bm, lo, c, hi;
        am = a & 'h1FFFF;
        bm = b & 'h1FFFF;
        if (!apx) return (am + bm) & 'h1FFFF;
        lo = (am | bm) & 3;
        c  = (am >> 1) & (bm >> 1) & 1;
        hi = ((am >> 2) + (bm >> 2) + c) & 'h7FFF;
        return (hi << 2) | lo;
    endfunction

    function automatic logic [15:0] model8(input int xv, input int zv, input logic apx);
        int acc, zr, t;
        acc = 0;
        zr  = zv;
        for (int i = 7; i >= 0; i--) begin
            if (zr >= 0) begin
                t  = xv * (1 << i);
                zr = zr - (1 << i);
            end else begin
                t  = -xv * (1 << i);
                zr = zr + (1 << i);
            end
            acc = add17(acc, t, apx);
        end
        if (zr == 1) acc = add17(acc, xv, apx);
        else if (zr == -1) acc = add17(acc, -xv, apx);
        return 16'(acc);
    endfunction

    task automatic run8(input logic [7:0] xv, input logic [7:0] zv, input logic apx,
                        output logic [15:0] yv, output int lat, output int bcnt);
        @(negedge clk);
        x8 = xv; z8 = zv; ae8 = apx; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        bcnt = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        yv = y8;
    endtask

    task automatic run12(input logic [11:0] xv, input logic [11:0] zv,
                         output logic [23:0] yv, output int lat);
        @(negedge clk);
        x12 = xv; z12 = zv; ae12 = 1'b1; start12 = 1'b1;
        @(posedge clk); #1;
        start12 = 1'b0;
        lat = 0;
        while (done12 !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        yv = y12;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8 got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8 got %b want 0", done8); end
        checks++; if (y8 !== 16'h0) begin errors++; $display("FAIL reset_y8 got %h want 0", y8); end
        checks++; if (busy12 !== 1'b0 || done12 !== 1'b0 || y12 !== 24'h0) begin
            errors++; $display("FAIL reset_dut12 got busy=%b done=%b y=%h want 0/0/0", busy12, done12, y12);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exact();
        int xv[4] = '{127, -128, -128, 5};
        int zv[4] = '{127, -128, 127, 0};
        int ev[4] = '{16129, 16384, -16256, 0};
        logic [15:0] yv;
        int lat, bcnt;
        for (int k = 0; k < 4; k++) begin
            run8(8'(xv[k]), 8'(zv[k]), 1'b0, yv, lat, bcnt);
            checks++; if (yv !== 16'(ev[k])) begin
                errors++; $display("FAIL exact_y x=%0d z=%0d got %h want %h", xv[k], zv[k], yv, 16'(ev[k]));
            end
            checks++; if (lat !== 10) begin
                errors++; $display("FAIL exact_latency x=%0d z=%0d got %0d want 10", xv[k], zv[k], lat);
            end
            checks++; if (bcnt !== 9) begin
                errors++; $display("FAIL exact_busy_cycles x=%0d z=%0d got %0d want 9", xv[k], zv[k], bcnt);
            end
        end
    endtask

    task automatic test_approx();
        int xv[3] = '{1, 3, 1};
        int zv[3] = '{0, 1, 0};
        logic am[3] = '{1'b1, 1'b1, 1'b0};
        int ev[3] = '{3, 3, 0};
        logic [15:0] yv;
        int lat, bcnt;
        for (int k = 0; k < 3; k++) begin
            run8(8'(xv[k]), 8'(zv[k]), am[k], yv, lat, bcnt);
            checks++; if (yv !== 16'(ev[k])) begin
                errors++; $display("FAIL approx_y x=%0d z=%0d apx=%b got %h want %h", xv[k], zv[k], am[k], yv, 16'(ev[k]));
            end
        end
    endtask

    task automatic test_sweep();
        int vals[32] = '{-128, -127, -100, -64, -33, -17, -8, -5, -3, -2, -1, 0, 1, 2, 3, 4,
                         5, 7, 8, 15, 16, 31, 37, 63, 64, 85, 100, 113, 120, 125, 126, 127};
        logic [15:0] yv, ev;
        int lat, bcnt, p, ya, n_err;
        real e, max_err, sum_err;
        max_err = 0.0;
        sum_err = 0.0;
        n_err = 0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                p = vals[a] * vals[b];
                run8(8'(vals[a]), 8'(vals[b]), 1'b0, yv, lat, bcnt);
                checks++; if (yv !== 16'(p)) begin
                    errors++; $display("FAIL sweep_exact x=%0d z=%0d got %h want %h", vals[a], vals[b], yv, 16'(p));
                end
                ev = model8(vals[a], vals[b], 1'b1);
                run8(8'(vals[a]), 8'(vals[b]), 1'b1, yv, lat, bcnt);
                checks++; if (yv !== ev) begin
                    errors++; $display("FAIL sweep_approx x=%0d z=%0d got %h want %h", vals[a], vals[b], yv, ev);
                end
                if (p != 0) begin
                    ya = int'($signed(yv));
                    e = real'(ya - p) / real'(p);
                    if (e < 0.0) e = -e;
                    if (e > max_err) max_err = e;
                    sum_err += e;
                    n_err++;
                end
            end
        end
        $display("approx sweep relative error: max %f mean %f over %0d products", max_err, sum_err / real'(n_err), n_err);
    endtask

    task automatic test_handshake();
        int dcount, dk;
        logic [15:0] ydone;
        dcount = 0;
        dk = -1;
        ydone = '0;
        @(negedge clk);
        x8 = 8'd100; z8 = 8'(-37); ae8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 3 || k == 9) begin
                start8 = 1'b1; x8 = 8'(-5); z8 = 8'd7;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                dcount++;
                if (dk < 0) dk = k;
                ydone = y8;
            end
        end
        checks++; if (dk !== 10) begin errors++; $display("FAIL ignore_start_done_time got %0d want 10", dk); end
        checks++; if (dcount !== 1) begin errors++; $display("FAIL ignore_start_done_count got %0d want 1", dcount); end
        checks++; if (ydone !== 16'(-3700)) begin errors++; $display("FAIL ignore_start_y got %h want %h", ydone, 16'(-3700)); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ignore_start_busy_after got %b want 0", busy8); end
    endtask

    task automatic test_back_to_back();
        int t1, t2, dcount;
        logic [15:0] y1, y2;
        t1 = -1; t2 = -1; dcount = 0; y1 = '0; y2 = '0;
        @(negedge clk);
        x8 = 8'd9; z8 = 8'(-11); ae8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start8 = (k <= 11);
            @(posedge clk); #1;
            if (done8 === 1'b1) begin
                dcount++;
                if (dcount == 1) begin t1 = k; y1 = y8; end
                else begin t2 = k; y2 = y8; end
            end
        end
        checks++; if (t1 !== 10) begin errors++; $display("FAIL b2b_first_done got %0d want 10", t1); end
        checks++; if (t2 !== 21) begin errors++; $display("FAIL b2b_second_done got %0d want 21", t2); end
        checks++; if (dcount !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", dcount); end
        checks++; if (y1 !== 16'(-99) || y2 !== 16'(-99)) begin
            errors++; $display("FAIL b2b_y got %h/%h want %h", y1, y2, 16'(-99));
        end
    endtask

    task automatic test_reset_mid();
        int seen, lat, bcnt;
        logic [15:0] yv;
        seen = 0;
        @(negedge clk);
        x8 = 8'd50; z8 = 8'd60; ae8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done8); end
        checks++; if (y8 !== 16'h0) begin errors++; $display("FAIL midreset_y got %h want 0", y8); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
        run8(8'(-77), 8'd45, 1'b0, yv, lat, bcnt);
        checks++; if (yv !== 16'(-3465)) begin errors++; $display("FAIL midreset_restart_y got %h want %h", yv, 16'(-3465)); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL midreset_restart_latency got %0d want 10", lat); end
    endtask

    task automatic test_param12();
        logic [23:0] yv;
        int lat;
        run12(12'(-2048), 12'd2047, yv, lat);
        checks++; if (yv !== 24'(-4192256)) begin errors++; $display("FAIL w12_y_a got %h want %h", yv, 24'(-4192256)); end
        checks++; if (lat !== 14) begin errors++; $display("FAIL w12_latency_a got %0d want 14", lat); end
        run12(12'(-2048), 12'(-2048), yv, lat);
        checks++; if (yv !== 24'd4194304) begin errors++; $display("FAIL w12_y_b got %h want %h", yv, 24'd4194304); end
        checks++; if (lat !== 14) begin errors++; $display("FAIL w12_latency_b got %0d want 14", lat); end
    endtask

    initial begin
        start8 = 1'b0; ae8 = 1'b0; x8 = '0; z8 = '0;
        start12 = 1'b0; ae12 = 1'b0; x12 = '0; z12 = '0;
        rst = 1'b1;
        test_reset();
        test_exact();
        test_approx();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_param12();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
